rs_arith_param: RTL and testbench
=================================

Name: rs_arith_param

Overview:
- Parametrised arithmetic reservation station for the out-of-order core.
- Sits between the dispatcher and the ALU, and snoops NUM_CDB result buses.
- Holds instructions until both operands are valid, then issues the oldest ready entry to the ALU over a valid/ready handshake.
- Adds the following to the previous RS generation: configurable depth, width and CDB count; oldest-first select; ALU back-pressure; flush; occupancy output.

Parameters:
RS_DEPTH, 16, number of entries (power of two, 2..64)
ROB_ID_W, 4, ROB tag width; tag 0 means "operand valid"
DATA_W, 32, operand/result width
OP_W, 6, opcode enum width; 0 = NOP
NUM_CDB, 2, number of result broadcast channels

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
rdy  in  1  global enable; low freezes all state
flush  in  1  misprediction squash
disp_valid  in  1  dispatch request
disp_op  in  OP_W  opcode
disp_q1  in  ROB_ID_W  src1 tag (0 = V1 valid)
disp_q2  in  ROB_ID_W  src2 tag (0 = V2 valid)
disp_v1  in  DATA_W  src1 value
disp_v2  in  DATA_W  src2 value
disp_imm  in  DATA_W  immediate
disp_pc  in  DATA_W  instruction pc
disp_rob_id  in  ROB_ID_W  destination tag
cdb_valid  in  NUM_CDB  per-channel broadcast valid
cdb_rob_id  in  NUM_CDB*ROB_ID_W  packed tags, channel k at [k*ROB_ID_W +: ROB_ID_W]
cdb_data  in  NUM_CDB*DATA_W  packed results, same packing
issue_valid  out  1  issue register holds an instruction
issue_ready  in  1  ALU accepts this cycle
issue_op  out  OP_W  opcode (NOP when invalid)
issue_v1  out  DATA_W  operand 1
issue_v2  out  DATA_W  operand 2
issue_imm  out  DATA_W  immediate
issue_pc  out  DATA_W  pc
issue_rob_id  out  ROB_ID_W  destination tag
full  out  1  count == RS_DEPTH
count  out  clog2(RS_DEPTH)+1  occupied entries

Behaviour:
- Reset (rst=0, async):
  - all entries not busy; count=0; full=0
  - issue_valid=0; issue_op=0; all other issue_* = 0
  - age state cleared
- rdy=0: no state change; outputs hold.
- Flush (rdy=1):
  - all entries freed; issue_valid=0; issue_op=0 at the edge
  - flush has priority over dispatch, issue and wakeup in the same cycle
- Dispatch:
  - if disp_valid && !full, write the lowest-index free entry at the edge.
  - if full, the request is ignored: no state change.
  - a slot freed by an issue in the same cycle is not reusable until the next cycle.
- Dispatch bypass: if disp_q1/q2 matches any valid cdb tag in the same cycle, the entry stores Q=0 and the broadcast data.
  - tag 0 never matches.
  - when several channels match, the lowest channel index wins.
- Wakeup: every busy entry with Qx == a valid cdb tag (nonzero) gets Qx=0 and Vx=data at the edge. Same lowest-channel priority applies.
- Ready condition: busy && Q1==0 && Q2==0, evaluated on registered state. A wakeup at edge E makes the entry selectable for edge E+1.
- Select: oldest ready entry by dispatch order, not by index; age is tracked by an age matrix or equivalent.
- Issue register load:
  - loads when (!issue_valid || issue_ready) and a ready entry exists.
  - the selected entry is freed at that edge.
  - if no entry is ready and (!issue_valid || issue_ready), then issue_valid=0 and issue_op=0.
  - while issue_valid && !issue_ready, issue_* hold stable and nothing is selected.
- Latency: dispatch with both operands valid at edge E0 gives issue_valid=1 after E0+1, at minimum.
- Count: +1 on an accepted dispatch, -1 on a select; both in the same cycle gives a net 0. full and count are registered-state derived.
- The issue register is not an RS entry: it is not counted and is not woken by the CDB; its operands are already final.

Test Plan:
- Reset, then dispatch op=3, q1=0, q2=0, v1=5, v2=7, rob=2 with issue_ready=1 -> two edges later issue_valid=1, issue_v1=5, issue_v2=7, issue_rob_id=2; count 1 -> 0.
- Dispatch A (rob=1, q1=4) then B (rob=2, q1=4); then cdb ch1 tag=4 data=0x99 -> A issues first with v1=0x99, B on the next accepted cycle; confirms oldest-first order, not index order.
- Dispatch with q2=6 while cdb ch0 tag=6 data=0x1234 is valid in the same cycle -> entry stored ready; issues with v2=0x1234 without any later broadcast.
- Fill 16 entries (count=16, full=1), hold issue_ready=0, dispatch a 17th -> ignored, count stays 16; the issue register holds its values stable for 5 cycles.
- With 3 entries plus issue_valid=1, assert flush together with disp_valid -> next cycle count=0, issue_valid=0, and the dispatched entry is discarded.
- Deassert rst asynchronously mid-operation (no clk edge) -> issue_valid=0, count=0 immediately; deassert rdy for 3 cycles with cdb activity -> state unchanged.

Source files
------------

// File: rtl/rs_arith_param.sv
// Arithmetic reservation station: holds dispatched ALU ops until both operands are
// valid (CDB wakeup/bypass), then issues the oldest ready entry over valid/ready.
module rs_arith_param #(
  parameter int RS_DEPTH = 16,
  parameter int ROB_ID_W = 4,
  parameter int DATA_W   = 32,
  parameter int OP_W     = 6,
  parameter int NUM_CDB  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic                         flush,
  input  logic                         disp_valid,
  input  logic [OP_W-1:0]              disp_op,
  input  logic [ROB_ID_W-1:0]          disp_q1,
  input  logic [ROB_ID_W-1:0]          disp_q2,
  input  logic [DATA_W-1:0]            disp_v1,
  input  logic [DATA_W-1:0]            disp_v2,
  input  logic [DATA_W-1:0]            disp_imm,
  input  logic [DATA_W-1:0]            disp_pc,
  input  logic [ROB_ID_W-1:0]          disp_rob_id,
  input  logic [NUM_CDB-1:0]           cdb_valid,
  input  logic [NUM_CDB*ROB_ID_W-1:0]  cdb_rob_id,
  input  logic [NUM_CDB*DATA_W-1:0]    cdb_data,
  output logic                         issue_valid,
  input  logic                         issue_ready,
  output logic [OP_W-1:0]              issue_op,
  output logic [DATA_W-1:0]            issue_v1,
  output logic [DATA_W-1:0]            issue_v2,
  output logic [DATA_W-1:0]            issue_imm,
  output logic [DATA_W-1:0]            issue_pc,
  output logic [ROB_ID_W-1:0]          issue_rob_id,
  output logic                         full,
  output logic [$clog2(RS_DEPTH):0]    count
);
  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int CNT_W = IDX_W + 1;

  typedef struct packed {
    logic              hit;
    logic [DATA_W-1:0] data;
  } snoop_t;

  // Lowest CDB channel wins; tag 0 means "already valid" and never matches.
  function automatic snoop_t cdb_snoop(input logic [ROB_ID_W-1:0] tag,
                                       input logic [NUM_CDB-1:0] vld,
                                       input logic [NUM_CDB*ROB_ID_W-1:0] tags,
                                       input logic [NUM_CDB*DATA_W-1:0] data);
    snoop_t res;
    res = '0;
    for (int k = NUM_CDB - 1; k >= 0; k--) begin
      if (vld[k] && (tag != {ROB_ID_W{1'b0}}) && (tags[k*ROB_ID_W +: ROB_ID_W] == tag)) begin
        res.hit  = 1'b1;
        res.data = data[k*DATA_W +: DATA_W];
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  logic [RS_DEPTH-1:0] busy_r;
  logic [OP_W-1:0]     op_r   [RS_DEPTH];
  logic [ROB_ID_W-1:0] q1_r   [RS_DEPTH];
  logic [ROB_ID_W-1:0] q2_r   [RS_DEPTH];
  logic [DATA_W-1:0]   v1_r   [RS_DEPTH];
  logic [DATA_W-1:0]   v2_r   [RS_DEPTH];
  logic [DATA_W-1:0]   imm_r  [RS_DEPTH];
  logic [DATA_W-1:0]   pc_r   [RS_DEPTH];
  logic [ROB_ID_W-1:0] rob_r  [RS_DEPTH];
  // older_r[i][j] set: entry j was dispatched before entry i
  logic [RS_DEPTH-1:0] older_r [RS_DEPTH];

  logic                issue_valid_r;
  logic [OP_W-1:0]     issue_op_r;
  logic [DATA_W-1:0]   issue_v1_r, issue_v2_r, issue_imm_r, issue_pc_r;
  logic [ROB_ID_W-1:0] issue_rob_r;
  logic [CNT_W-1:0]    count_r;
  logic                full_r;

  logic [RS_DEPTH-1:0] ready_s;
  logic                free_found_s, sel_found_s;
  logic [IDX_W-1:0]    free_idx_s, sel_idx_s;
  logic                can_load_s, take_s, disp_acc_s;
  logic [CNT_W-1:0]    count_next_s;
  snoop_t              d1_s, d2_s;
  snoop_t              wk1_s [RS_DEPTH];
  snoop_t              wk2_s [RS_DEPTH];

  // Free-slot search, oldest-ready select, CDB snoops and occupancy update.
  always_comb begin
    ready_s      = '0;
    free_found_s = 1'b0;
    free_idx_s   = '0;
    sel_found_s  = 1'b0;
    sel_idx_s    = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      ready_s[i] = busy_r[i] && (q1_r[i] == {ROB_ID_W{1'b0}}) && (q2_r[i] == {ROB_ID_W{1'b0}});
      wk1_s[i]   = cdb_snoop(q1_r[i], cdb_valid, cdb_rob_id, cdb_data);
      wk2_s[i]   = cdb_snoop(q2_r[i], cdb_valid, cdb_rob_id, cdb_data);
    end
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!busy_r[i]) begin
        free_found_s = 1'b1;
        free_idx_s   = IDX_W'(i);
      end else begin
        free_found_s = free_found_s;
      end
      // Ready entry with no older ready entry; the age order makes this unique.
      if (ready_s[i] && ((older_r[i] & ready_s) == {RS_DEPTH{1'b0}})) begin
        sel_found_s = 1'b1;
        sel_idx_s   = IDX_W'(i);
      end else begin
        sel_found_s = sel_found_s;
      end
    end
    d1_s         = cdb_snoop(disp_q1, cdb_valid, cdb_rob_id, cdb_data);
    d2_s         = cdb_snoop(disp_q2, cdb_valid, cdb_rob_id, cdb_data);
    can_load_s   = !issue_valid_r || issue_ready;
    take_s       = can_load_s && sel_found_s;
    disp_acc_s   = disp_valid && !full_r && free_found_s;
    count_next_s = count_r + CNT_W'(disp_acc_s) - CNT_W'(take_s);
  end

  // Entry array, age matrix, issue register and occupancy state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r        <= '0;
      issue_valid_r <= 1'b0;
      issue_op_r    <= '0;
      issue_v1_r    <= '0;
      issue_v2_r    <= '0;
      issue_imm_r   <= '0;
      issue_pc_r    <= '0;
      issue_rob_r   <= '0;
      count_r       <= '0;
      full_r        <= 1'b0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        op_r[i]    <= '0;
        q1_r[i]    <= '0;
        q2_r[i]    <= '0;
        v1_r[i]    <= '0;
        v2_r[i]    <= '0;
        imm_r[i]   <= '0;
        pc_r[i]    <= '0;
        rob_r[i]   <= '0;
        older_r[i] <= '0;
      end
    end else if (rdy) begin
      if (flush) begin
        busy_r        <= '0;
        issue_valid_r <= 1'b0;
        issue_op_r    <= '0;
        count_r       <= '0;
        full_r        <= 1'b0;
      end else begin
        for (int i = 0; i < RS_DEPTH; i++) begin
          if (busy_r[i] && wk1_s[i].hit) begin
            q1_r[i] <= '0;
            v1_r[i] <= wk1_s[i].data;
          end
          if (busy_r[i] && wk2_s[i].hit) begin
            q2_r[i] <= '0;
            v2_r[i] <= wk2_s[i].data;
          end
        end
        if (disp_acc_s) begin
          busy_r[free_idx_s]  <= 1'b1;
          op_r[free_idx_s]    <= disp_op;
          q1_r[free_idx_s]    <= d1_s.hit ? {ROB_ID_W{1'b0}} : disp_q1;
          q2_r[free_idx_s]    <= d2_s.hit ? {ROB_ID_W{1'b0}} : disp_q2;
          v1_r[free_idx_s]    <= d1_s.hit ? d1_s.data : disp_v1;
          v2_r[free_idx_s]    <= d2_s.hit ? d2_s.data : disp_v2;
          imm_r[free_idx_s]   <= disp_imm;
          pc_r[free_idx_s]    <= disp_pc;
          rob_r[free_idx_s]   <= disp_rob_id;
          older_r[free_idx_s] <= busy_r;
          for (int j = 0; j < RS_DEPTH; j++) begin
            if (IDX_W'(j) != free_idx_s) begin
              older_r[j][free_idx_s] <= 1'b0;
            end
          end
        end
        if (take_s) begin
          busy_r[sel_idx_s] <= 1'b0;
          issue_valid_r     <= 1'b1;
          issue_op_r        <= op_r[sel_idx_s];
          issue_v1_r        <= v1_r[sel_idx_s];
          issue_v2_r        <= v2_r[sel_idx_s];
          issue_imm_r       <= imm_r[sel_idx_s];
          issue_pc_r        <= pc_r[sel_idx_s];
          issue_rob_r       <= rob_r[sel_idx_s];
        end else if (can_load_s) begin
          issue_valid_r <= 1'b0;
          issue_op_r    <= '0;
        end
        count_r <= count_next_s;
        full_r  <= (count_next_s == CNT_W'(RS_DEPTH));
      end
    end
  end

  assign issue_valid  = issue_valid_r;
  assign issue_op     = issue_op_r;
  assign issue_v1     = issue_v1_r;
  assign issue_v2     = issue_v2_r;
  assign issue_imm    = issue_imm_r;
  assign issue_pc     = issue_pc_r;
  assign issue_rob_id = issue_rob_r;
  assign count        = count_r;
  assign full         = full_r;
endmodule

// File: tb/tb_rs_arith_param.sv
// Self-checking bench for rs_arith_param: directed vector table, hand-written corner
// sequences and random stimulus against a dispatch-ordered queue model.
module tb_rs_arith_param;
  localparam int D  = 16;
  localparam int RW = 4;
  localparam int DW = 32;
  localparam int OW = 6;
  localparam int NC = 2;

  logic clk = 1'b0;
  logic rst, rdy, flush, disp_valid, issue_ready;
  logic [OW-1:0] disp_op;
  logic [RW-1:0] disp_q1, disp_q2, disp_rob_id;
  logic [DW-1:0] disp_v1, disp_v2, disp_imm, disp_pc;
  logic [NC-1:0] cdb_valid;
  logic [NC*RW-1:0] cdb_rob_id;
  logic [NC*DW-1:0] cdb_data;
  logic issue_valid, full;
  logic [OW-1:0] issue_op;
  logic [DW-1:0] issue_v1, issue_v2, issue_imm, issue_pc;
  logic [RW-1:0] issue_rob_id;
  logic [$clog2(D):0] count;

  always #5 clk = ~clk;

  rs_arith_param #(.RS_DEPTH(D), .ROB_ID_W(RW), .DATA_W(DW), .OP_W(OW), .NUM_CDB(NC)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .disp_valid(disp_valid),
    .disp_op(disp_op), .disp_q1(disp_q1), .disp_q2(disp_q2), .disp_v1(disp_v1),
    .disp_v2(disp_v2), .disp_imm(disp_imm), .disp_pc(disp_pc), .disp_rob_id(disp_rob_id),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_v1(issue_v1), .issue_v2(issue_v2), .issue_imm(issue_imm), .issue_pc(issue_pc),
    .issue_rob_id(issue_rob_id), .full(full), .count(count));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: entries kept in dispatch order, so "oldest ready" is the first match.
  typedef struct {
    logic [OW-1:0] op;
    logic [RW-1:0] q1, q2, rob;
    logic [DW-1:0] v1, v2, imm, pc;
  } ent_t;

  ent_t m_q[$];
  logic m_iv;
  ent_t m_is;

  function automatic void model_reset();
    m_q.delete();
    m_iv = 1'b0;
    m_is = '{default: '0};
  endfunction

  function automatic void snoop(input logic [RW-1:0] tag, output logic hit, output logic [DW-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (tag != '0)
      for (int k = 0; k < NC; k++)
        if (!hit && cdb_valid[k] && cdb_rob_id[k*RW +: RW] == tag) begin
          hit = 1'b1;
          d   = cdb_data[k*DW +: DW];
        end
  endfunction

  function automatic void model_edge();
    int take;
    logic h;
    logic [DW-1:0] d;
    ent_t e;
    bit can_load, accept;
    if (!rdy) return;
    if (flush) begin
      m_q.delete();
      m_iv = 1'b0;
      m_is.op = '0;
      return;
    end
    can_load = !m_iv || issue_ready;
    accept   = disp_valid && (m_q.size() < D);
    take     = -1;
    if (can_load)
      foreach (m_q[i])
        if (take < 0 && m_q[i].q1 == 0 && m_q[i].q2 == 0) take = i;
    foreach (m_q[i]) begin
      snoop(m_q[i].q1, h, d);
      if (h) begin m_q[i].q1 = '0; m_q[i].v1 = d; end
      snoop(m_q[i].q2, h, d);
      if (h) begin m_q[i].q2 = '0; m_q[i].v2 = d; end
    end
    if (take >= 0) begin
      m_iv = 1'b1;
      m_is = m_q[take];
      m_q.delete(take);
    end else if (can_load) begin
      m_iv = 1'b0;
      m_is.op = '0;
    end
    if (accept) begin
      e = '{op: disp_op, q1: disp_q1, q2: disp_q2, rob: disp_rob_id,
            v1: disp_v1, v2: disp_v2, imm: disp_imm, pc: disp_pc};
      snoop(disp_q1, h, d);
      if (h) begin e.q1 = '0; e.v1 = d; end
      snoop(disp_q2, h, d);
      if (h) begin e.q2 = '0; e.v2 = d; end
      m_q.push_back(e);
    end
  endfunction

  task automatic compare_model();
    chk("count", count, m_q.size());
    chk("full", full, (m_q.size() == D));
    chk("issue_valid", issue_valid, m_iv);
    if (m_iv) begin
      chk("issue_op", issue_op, m_is.op);
      chk("issue_v1", issue_v1, m_is.v1);
      chk("issue_v2", issue_v2, m_is.v2);
      chk("issue_imm", issue_imm, m_is.imm);
      chk("issue_pc", issue_pc, m_is.pc);
      chk("issue_rob_id", issue_rob_id, m_is.rob);
    end else begin
      chk("issue_op_nop", issue_op, '0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    cdb_valid  = '0;
    flush      = 1'b0;
    rdy        = 1'b1;
  endtask

  task automatic set_disp(input logic v, input logic [OW-1:0] op, input logic [RW-1:0] q1,
                          input logic [RW-1:0] q2, input logic [RW-1:0] rob,
                          input logic [DW-1:0] v1, input logic [DW-1:0] v2);
    disp_valid  = v;
    disp_op     = op;
    disp_q1     = q1;
    disp_q2     = q2;
    disp_rob_id = rob;
    disp_v1     = v1;
    disp_v2     = v2;
    disp_imm    = v1 ^ 32'hFFFF_0000;
    disp_pc     = 32'h0000_1000 + {28'h0, rob};
  endtask

  task automatic set_cdb(input int ch, input logic [RW-1:0] tag, input logic [DW-1:0] data);
    cdb_valid = '0;
    if (ch >= 0) begin
      cdb_valid[ch]            = 1'b1;
      cdb_rob_id[ch*RW +: RW]  = tag;
      cdb_data[ch*DW +: DW]    = data;
    end
  endtask

  typedef struct {
    logic          dv;
    logic [RW-1:0] q1, q2, rob;
    logic [DW-1:0] v1, v2;
    int            cch;
    logic [RW-1:0] ctag;
    logic [DW-1:0] cdat;
    logic          ev;
    logic [RW-1:0] erob;
    logic [DW-1:0] ev1, ev2;
    int            ecnt;
  } vec_t;

  vec_t vt[13];

  initial begin
    // dv q1 q2 rob v1 v2 | cdb ch/tag/data | exp valid rob v1 v2 count
    vt[0]  = '{1'b1, 4'd0, 4'd0, 4'd2, 32'd5,   32'd7,    -1, 4'd0, 32'h0,    1'b0, 4'd0, 32'h0,  32'h0,    1};
    vt[1]  = '{1'b0, 4'd0, 4'd0, 4'd0, 32'd0,   32'd0,    -1, 4'd0, 32'h0,    1'b1, 4'd2, 32'd5,  32'd7,    0};
    vt[2]  = '{1'b0, 4'd0, 4'd0, 4'd0, 32'd0,   32'd0,    -1, 4'd0, 32'h0,    1'b0, 4'd0, 32'h0,  32'h0,    0};
    vt[3]  = '{1'b1, 4'd0, 4'd0, 4'd3, 32'hA,   32'hB,    -1, 4'd0, 32'h0,    1'b0, 4'd0, 32'h0,  32'h0,    1};
    vt[4]  = '{1'b1, 4'd4, 4'd0, 4'd1, 32'd0,   32'h22,   -1, 4'd0, 32'h0,    1'b1, 4'd3, 32'hA,  32'hB,    1};
    vt[5]  = '{1'b1, 4'd4, 4'd0, 4'd2, 32'd0,   32'h33,   -1, 4'd0, 32'h0,    1'b0, 4'd0, 32'h0,  32'h0,    2};
    vt[6]  = '{1'b0, 4'd0, 4'd0, 4'd0, 32'd0,   32'd0,     1, 4'd4, 32'h99,   1'b0, 4'd0, 32'h0,  32'h0,    2};
    vt[7]  = '{1'b0, 4'd0, 4'd0, 4'd0, 32'd0,   32'd0,    -1, 4'd0, 32'h0,    1'b1, 4'd1, 32'h99, 32'h22,   1};
    vt[8]  = '{1'b0, 4'd0, 4'd0, 4'd0, 32'd0,   32'd0,    -1, 4'd0, 32'h0,    1'b1, 4'd2, 32'h99, 32'h33,   0};
    vt[9]  = '{1'b0, 4'd0, 4'd0, 4'd0, 32'd0,   32'd0,    -1, 4'd0, 32'h0,    1'b0, 4'd0, 32'h0,  32'h0,    0};
    vt[10] = '{1'b1, 4'd0, 4'd6, 4'd5, 32'd1,   32'd0,     0, 4'd6, 32'h1234, 1'b0, 4'd0, 32'h0,  32'h0,    1};
    vt[11] = '{1'b0, 4'd0, 4'd0, 4'd0, 32'd0,   32'd0,    -1, 4'd0, 32'h0,    1'b1, 4'd5, 32'd1,  32'h1234, 0};
    vt[12] = '{1'b0, 4'd0, 4'd0, 4'd0, 32'd0,   32'd0,    -1, 4'd0, 32'h0,    1'b0, 4'd0, 32'h0,  32'h0,    0};

    rst = 1'b0; issue_ready = 1'b1; cdb_rob_id = '0; cdb_data = '0;
    idle();
    set_disp(1'b0, '0, '0, '0, '0, '0, '0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_count", count, 0);
    chk("reset_full", full, 0);
    chk("reset_issue_valid", issue_valid, 0);
    chk("reset_issue_op", issue_op, 0);
    chk("reset_issue_v1", issue_v1, 0);
    chk("reset_issue_rob", issue_rob_id, 0);
    @(negedge clk);
    rst = 1'b1;

    // Directed vector table: latency, oldest-first across indices, dispatch bypass.
    for (int r = 0; r < 13; r++) begin
      set_disp(vt[r].dv, 6'd3, vt[r].q1, vt[r].q2, vt[r].rob, vt[r].v1, vt[r].v2);
      set_cdb(vt[r].cch, vt[r].ctag, vt[r].cdat);
      tick();
      chk($sformatf("vec%0d_count", r), count, vt[r].ecnt);
      chk($sformatf("vec%0d_valid", r), issue_valid, vt[r].ev);
      if (vt[r].ev) begin
        chk($sformatf("vec%0d_rob", r), issue_rob_id, vt[r].erob);
        chk($sformatf("vec%0d_v1", r), issue_v1, vt[r].ev1);
        chk($sformatf("vec%0d_v2", r), issue_v2, vt[r].ev2);
      end
    end
    idle();

    // Fill under back-pressure; the first ready entry parks in the issue register.
    issue_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      set_disp(1'b1, 6'd3, 4'd0, 4'd0, RW'(i), 32'h1000 + i, DW'(i));
      tick();
    end
    chk("fill_count", count, 16);
    chk("fill_full", full, 1);
    set_disp(1'b1, 6'd4, 4'd0, 4'd0, 4'd15, 32'hDEAD, 32'hBEEF);
    tick();
    chk("overflow_count", count, 16);
    idle();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", issue_valid, 1);
      chk("hold_v1", issue_v1, 32'h1000);
      chk("hold_rob", issue_rob_id, 0);
    end

    // Flush beats a same-cycle dispatch.
    flush = 1'b1;
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      set_disp(1'b1, 6'd5, 4'd0, 4'd0, RW'(i + 8), 32'h50 + i, 32'h60);
      tick();
    end
    chk("preflush_count", count, 3);
    chk("preflush_valid", issue_valid, 1);
    set_disp(1'b1, 6'd5, 4'd0, 4'd0, 4'd12, 32'h77, 32'h78);
    flush = 1'b1;
    tick();
    chk("flush_count", count, 0);
    chk("flush_valid", issue_valid, 0);
    chk("flush_op", issue_op, 0);
    idle();
    issue_ready = 1'b1;
    tick();
    chk("postflush_count", count, 0);
    chk("postflush_valid", issue_valid, 0);

    // Asynchronous reset in mid-cycle.
    issue_ready = 1'b0;
    set_disp(1'b1, 6'd2, 4'd0, 4'd0, 4'd3, 32'h1, 32'h2);
    tick();
    tick();
    chk("prerst_valid", issue_valid, 1);
    idle();
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("async_rst_valid", issue_valid, 0);
    chk("async_rst_count", count, 0);
    @(negedge clk);
    rst = 1'b1;

    // rdy low freezes everything despite dispatch, CDB and issue_ready activity.
    set_disp(1'b1, 6'd1, 4'd0, 4'd0, 4'd1, 32'h11, 32'h12);
    tick();
    set_disp(1'b1, 6'd1, 4'd4, 4'd0, 4'd2, 32'h0, 32'h13);
    tick();
    set_disp(1'b1, 6'd1, 4'd4, 4'd0, 4'd3, 32'h0, 32'h14);
    tick();
    rdy = 1'b0;
    issue_ready = 1'b1;
    set_cdb(0, 4'd4, 32'hCAFE);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frozen_count", count, 2);
      chk("frozen_valid", issue_valid, 1);
      chk("frozen_rob", issue_rob_id, 1);
    end
    idle();

    // Random traffic against the queue model.
    for (int c = 0; c < 800; c++) begin
      rdy         = ($urandom_range(0, 9) != 0);
      flush       = ($urandom_range(0, 49) == 0);
      issue_ready = ($urandom_range(0, 9) < 7);
      set_disp($urandom_range(0, 9) < 6, OW'($urandom_range(1, 63)),
               ($urandom_range(0, 1) == 0) ? 4'd0 : RW'($urandom_range(1, 7)),
               ($urandom_range(0, 1) == 0) ? 4'd0 : RW'($urandom_range(1, 7)),
               RW'($urandom), $urandom, $urandom);
      for (int k = 0; k < NC; k++) begin
        cdb_valid[k]           = $urandom_range(0, 1);
        cdb_rob_id[k*RW +: RW] = RW'($urandom_range(0, 7));
        cdb_data[k*DW +: DW]   = $urandom;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
